usb_bitstream_rx: RTL and testbench

Receive-side counterpart of the USB transmit bitstream serializer. It accepts NRZI-decoded bits from the line decoder and hunts for SYNC. It removes stuffed zeros, assembles LSB-first bytes and detects end-of-packet. Output is a byte stream with packet-start, packet-done and error pulses, passed to the packet decoder.

---
 rtl/usb_pkg.sv | 6 +
 rtl/usb_bitstream_rx_if.sv | 21 ++
 rtl/usb_unstuff.sv | 33 +++
 rtl/usb_bitstream_rx.sv | 107 ++++++++++
 tb/tb_usb_bitstream_rx.sv | 167 ++++++++++++++++
 5 files changed

// File: rtl/usb_pkg.sv
// usb_pkg: shared types and constants for the USB bitstream receiver
package usb_pkg;
   typedef enum logic {IDLE, RECV} state_e;
   localparam logic [7:0] SYNC_PATTERN = 8'h80;
   localparam int STUFF_LEN_DEF = 6;
endpackage

// File: rtl/usb_bitstream_rx_if.sv
// usb_bitstream_rx_if: line-decoder bit inputs and packet-decoder byte outputs
interface usb_bitstream_rx_if;
   logic       bit_in;
   logic       bit_valid;
   logic       eop;
   logic [7:0] byte_out;
   logic       byte_valid;
   logic       stream_begin;
   logic       stream_done;
   logic       stuff_err;
   logic       align_err;
   logic       busy;
   modport master (
      output bit_in, bit_valid, eop,
      input  byte_out, byte_valid, stream_begin, stream_done, stuff_err, align_err, busy
   );
   modport slave (
      input  bit_in, bit_valid, eop,
      output byte_out, byte_valid, stream_begin, stream_done, stuff_err, align_err, busy
   );
endinterface

// File: rtl/usb_unstuff.sv
// usb_unstuff: tracks the run of ones and classifies each received bit as data, stuffed zero or violation
module usb_unstuff
   import usb_pkg::*;
#(
   parameter int STUFF_LEN = STUFF_LEN_DEF
) (
   input  logic clk,
   input  logic rst_b,
   input  logic load_one,
   input  logic in_valid,
   input  logic in_bit,
   output logic data_valid,
   output logic data_bit,
   output logic stuff_err
);
   localparam int W = $clog2(STUFF_LEN + 1);
   logic [W-1:0] ones_cnt_q, ones_cnt_d;
   logic         full;
   always_comb begin
      full       = ones_cnt_q == W'(STUFF_LEN);
      data_valid = in_valid && !full;
      data_bit   = in_bit;
      stuff_err  = in_valid && full && in_bit;
      // the SYNC ends in a one, so the run starts at one on entry to RECV
      ones_cnt_d = load_one ? W'(1) :
                   !in_valid ? ones_cnt_q :
                   (full || !in_bit) ? '0 : ones_cnt_q + 1'b1;
   end
   always_ff @(posedge clk) begin
      if (!rst_b) ones_cnt_q <= '0;
      else        ones_cnt_q <= ones_cnt_d;
   end
endmodule

// File: rtl/usb_bitstream_rx.sv
// usb_bitstream_rx: SYNC hunt, bit unstuffing, LSB-first byte assembly and EOP framing
module usb_bitstream_rx
   import usb_pkg::*;
#(
   parameter int STUFF_LEN = STUFF_LEN_DEF
) (
   input logic               clk,
   input logic               rst_b,
   usb_bitstream_rx_if.slave bus
);
   state_e     state_q, state_d;
   logic [7:0] hunt_q, hunt_d;
   logic [2:0] bit_cnt_q, bit_cnt_d;
   logic [7:0] shreg_q, shreg_d;
   logic [7:0] byte_out_q, byte_out_d;
   logic       byte_valid_q, byte_valid_d;
   logic       stream_begin_q, stream_begin_d;
   logic       stream_done_q, stream_done_d;
   logic       stuff_err_q, stuff_err_d;
   logic       align_err_q, align_err_d;
   logic       busy_q, busy_d;
   logic       sync_hit, recv_bit;
   logic       dv, db, se;
   assign sync_hit = state_q == IDLE && bus.bit_valid && {bus.bit_in, hunt_q[7:1]} == SYNC_PATTERN;
   assign recv_bit = state_q == RECV && bus.bit_valid && !bus.eop;
   usb_unstuff #(.STUFF_LEN(STUFF_LEN)) u_unstuff (
      .clk        (clk),
      .rst_b      (rst_b),
      .load_one   (sync_hit),
      .in_valid   (recv_bit),
      .in_bit     (bus.bit_in),
      .data_valid (dv),
      .data_bit   (db),
      .stuff_err  (se)
   );
   always_comb begin
      state_d        = state_q;
      hunt_d         = hunt_q;
      bit_cnt_d      = bit_cnt_q;
      shreg_d        = shreg_q;
      byte_out_d     = byte_out_q;
      byte_valid_d   = 1'b0;
      stream_begin_d = 1'b0;
      stream_done_d  = 1'b0;
      stuff_err_d    = 1'b0;
      align_err_d    = 1'b0;
      if (state_q == IDLE) begin
         if (bus.bit_valid) hunt_d = {bus.bit_in, hunt_q[7:1]};
         if (sync_hit) begin
            state_d        = RECV;
            stream_begin_d = 1'b1;
            bit_cnt_d      = '0;
         end
      end else if (bus.eop) begin
         stream_done_d = bit_cnt_q == 3'd0;
         align_err_d   = bit_cnt_q != 3'd0;
         state_d       = IDLE;
         hunt_d        = '0;
      end else if (se) begin
         stuff_err_d = 1'b1;
         state_d     = IDLE;
      end else if (dv) begin
         // newest bit enters at the MSB so the first bit lands at the LSB after eight shifts
         shreg_d   = {db, shreg_q[7:1]};
         bit_cnt_d = bit_cnt_q + 3'd1;
         if (bit_cnt_q == 3'd7) begin
            byte_out_d   = shreg_d;
            byte_valid_d = 1'b1;
         end
      end
      busy_d = state_d == RECV;
   end
   always_ff @(posedge clk) begin
      if (!rst_b) begin
         state_q        <= IDLE;
         hunt_q         <= '0;
         bit_cnt_q      <= '0;
         shreg_q        <= '0;
         byte_out_q     <= '0;
         byte_valid_q   <= 1'b0;
         stream_begin_q <= 1'b0;
         stream_done_q  <= 1'b0;
         stuff_err_q    <= 1'b0;
         align_err_q    <= 1'b0;
         busy_q         <= 1'b0;
      end else begin
         state_q        <= state_d;
         hunt_q         <= hunt_d;
         bit_cnt_q      <= bit_cnt_d;
         shreg_q        <= shreg_d;
         byte_out_q     <= byte_out_d;
         byte_valid_q   <= byte_valid_d;
         stream_begin_q <= stream_begin_d;
         stream_done_q  <= stream_done_d;
         stuff_err_q    <= stuff_err_d;
         align_err_q    <= align_err_d;
         busy_q         <= busy_d;
      end
   end
   assign bus.byte_out     = byte_out_q;
   assign bus.byte_valid   = byte_valid_q;
   assign bus.stream_begin = stream_begin_q;
   assign bus.stream_done  = stream_done_q;
   assign bus.stuff_err    = stuff_err_q;
   assign bus.align_err    = align_err_q;
   assign bus.busy         = busy_q;
endmodule

// File: tb/tb_usb_bitstream_rx.sv
// tb_usb_bitstream_rx: directed packets with a cycle-stamped event scoreboard
module tb_usb_bitstream_rx;
   localparam int EV_BEGIN = 0;
   localparam int EV_BYTE  = 1;
   localparam int EV_DONE  = 2;
   localparam int EV_STUFF = 3;
   localparam int EV_ALIGN = 4;
   typedef struct {
      int         kind;
      logic [7:0] data;
      int         at;
   } ev_t;
   logic clk = 1'b0;
   logic rst_b = 1'b0;
   int   cyc_n = 0;
   int   tests = 0;
   int   fails = 0;
   ev_t  sb[$];
   usb_bitstream_rx_if bus ();
   usb_bitstream_rx dut (
      .clk   (clk),
      .rst_b (rst_b),
      .bus   (bus)
   );
   always #5 clk = ~clk;
   always @(posedge clk) cyc_n <= cyc_n + 1;
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc_n);
      end
   endtask
   task automatic drive(input logic v, input logic b, input logic e);
      @(negedge clk);
      bus.bit_valid = v;
      bus.bit_in    = b;
      bus.eop       = e;
   endtask
   task automatic expect_ev(input int k, input logic [7:0] d);
      sb.push_back('{kind: k, data: d, at: cyc_n + 1});
   endtask
   task automatic idle(input int n);
      repeat (n) drive(1'b0, 1'b0, 1'b0);
   endtask
   task automatic send_sync();
      repeat (7) drive(1'b1, 1'b0, 1'b0);
      drive(1'b1, 1'b1, 1'b0);
      expect_ev(EV_BEGIN, 8'h00);
   endtask
   task automatic send_byte(input logic [7:0] d, input bit gaps);
      for (int i = 0; i < 8; i++) begin
         drive(1'b1, d[i], 1'b0);
         if (i == 7) expect_ev(EV_BYTE, d);
         if (gaps) idle(int'($urandom_range(0, 3)));
      end
   endtask
   task automatic send_eop(input logic spurious, input int k);
      drive(spurious, 1'b1, 1'b1);
      expect_ev(k, 8'h00);
      idle(1);
   endtask
   always @(negedge clk) begin
      logic [4:0] p;
      ev_t e;
      p = {bus.align_err === 1'b1, bus.stuff_err === 1'b1, bus.stream_done === 1'b1,
           bus.byte_valid === 1'b1, bus.stream_begin === 1'b1};
      for (int k = 0; k < 5; k++) begin
         if (p[k]) begin
            if (sb.size() == 0) chk($sformatf("spurious_pulse_k%0d", k), p[k], 1'b0);
            else begin
               e = sb.pop_front();
               chk("ev_kind", k, e.kind);
               chk("ev_cycle", cyc_n, e.at);
               if (k == EV_BYTE) chk("byte_out", bus.byte_out, e.data);
            end
         end
      end
      if (sb.size() > 0 && sb[0].at <= cyc_n) begin
         e = sb.pop_front();
         chk($sformatf("event_k%0d_seen", e.kind), p[e.kind], 1'b1);
      end
   end
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
      $fatal(1, "watchdog");
   end
   initial begin
      bus.bit_valid = 1'b0;
      bus.bit_in    = 1'b0;
      bus.eop       = 1'b0;
      idle(3);
      chk("reset_byte_out", bus.byte_out, 8'h00);
      chk("reset_busy", bus.busy, 1'b0);
      chk("reset_pulses", {bus.byte_valid, bus.stream_begin, bus.stream_done, bus.stuff_err, bus.align_err}, 5'b0);
      @(negedge clk) rst_b = 1'b1;
      idle(2);
      // basic byte
      send_sync();
      idle(1);
      chk("busy_in_recv", bus.busy, 1'b1);
      send_byte(8'hA5, 1'b0);
      send_eop(1'b0, EV_DONE);
      idle(3);
      chk("busy_after_done", bus.busy, 1'b0);
      chk("byte_out_holds", bus.byte_out, 8'hA5);
      // stuffed zero after five data ones (six counting the SYNC one)
      send_sync();
      for (int i = 0; i < 9; i++) begin
         drive(1'b1, i != 5, 1'b0);
         if (i == 8) expect_ev(EV_BYTE, 8'hFF);
      end
      send_eop(1'b0, EV_DONE);
      idle(3);
      // stuff violation then recovery
      send_sync();
      for (int i = 0; i < 6; i++) begin
         drive(1'b1, 1'b1, 1'b0);
         if (i == 5) expect_ev(EV_STUFF, 8'h00);
      end
      idle(2);
      chk("busy_after_stuff_err", bus.busy, 1'b0);
      chk("byte_out_after_stuff_err", bus.byte_out, 8'hFF);
      send_sync();
      send_byte(8'h3C, 1'b0);
      send_eop(1'b0, EV_DONE);
      idle(3);
      // EOP with partial byte
      send_sync();
      drive(1'b1, 1'b1, 1'b0);
      drive(1'b1, 1'b0, 1'b0);
      drive(1'b1, 1'b1, 1'b0);
      send_eop(1'b0, EV_ALIGN);
      idle(3);
      chk("busy_after_align_err", bus.busy, 1'b0);
      chk("byte_out_after_align_err", bus.byte_out, 8'h3C);
      // gapped byte, eop together with a bit that must be dropped
      send_sync();
      send_byte(8'h5A, 1'b1);
      send_eop(1'b1, EV_DONE);
      idle(3);
      chk("byte_out_5a", bus.byte_out, 8'h5A);
      // reset mid-packet
      send_sync();
      drive(1'b1, 1'b1, 1'b0);
      drive(1'b1, 1'b0, 1'b0);
      drive(1'b1, 1'b1, 1'b0);
      drive(1'b1, 1'b1, 1'b0);
      @(negedge clk);
      bus.bit_valid = 1'b0;
      rst_b = 1'b0;
      @(negedge clk);
      rst_b = 1'b1;
      chk("midreset_byte_out", bus.byte_out, 8'h00);
      chk("midreset_busy", bus.busy, 1'b0);
      idle(2);
      send_sync();
      send_byte(8'h01, 1'b0);
      send_eop(1'b0, EV_DONE);
      idle(5);
      chk("byte_out_01", bus.byte_out, 8'h01);
      chk("scoreboard_drained", sb.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
